// File: rtl/mult_shift_add_ctrl_pkg.sv
// Shared calculator definitions: FSM encodings, default operand width and
// helpers common to the calc blocks.
package mult_shift_add_ctrl_pkg;

    localparam int unsigned CALC_WIDTH = 8;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_RUN  = 2'b01;
    localparam logic [ST_W-1:0] ST_DONE = 2'b10;

    // Counter width needed to count width iterations (0 .. width).
    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_shift_add_ctrl_full_adder.sv
// Ripple-carry width-bit adder with carry in and carry out; the single
// arithmetic resource of the shift-add multiplier.
module full_adder_wcarry_nbits
    import mult_shift_add_ctrl_pkg::*;
#(
    parameter int unsigned width = CALC_WIDTH
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit.
    for (genvar i = 0; i < width; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[width];

endmodule

// File: rtl/mult_shift_add_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one adder iteration per cycle,
// width cycles from accepted start to a single-cycle done pulse.
module mult_shift_add_ctrl
    import mult_shift_add_ctrl_pkg::*;
#(
    parameter int unsigned width = CALC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [width-1:0]     a_i,
    input  logic [width-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*width-1:0]   p_o
);

    localparam int unsigned CW = count_width(width);
    localparam logic [CW-1:0] LAST_ITER = CW'(width - 1);

    logic [ST_W-1:0]    state_q;
    logic [ST_W-1:0]    state_d;
    logic [width-1:0]   m_q;
    logic [width-1:0]   m_d;
    logic [width-1:0]   q_q;
    logic [width-1:0]   q_d;
    logic [width-1:0]   acc_q;
    logic [width-1:0]   acc_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               busy_d;
    logic               done_d;
    logic [2*width-1:0] p_d;

    logic [width-1:0]   addend_c;
    logic [width-1:0]   sum_c;
    logic               carry_c;

    assign addend_c = q_q[0] ? m_q : '0;

    full_adder_wcarry_nbits #(
        .width (width)
    ) u_adder (
        .a    (acc_q),
        .b    (addend_c),
        .cin  (1'b0),
        .sum  (sum_c),
        .cout (carry_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        count_d = count_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        p_d     = p_o;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    m_d     = a_i;
                    q_d     = b_i;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // {ACC,Q} <= {C,S,Q} >> 1; carry becomes the new ACC msb.
                acc_d   = {carry_c, sum_c[width-1:1]};
                q_d     = {sum_c[0], q_q[width-1:1]};
                count_d = count_q + CW'(1);
                busy_d  = 1'b1;
                if (count_q == LAST_ITER) begin
                    p_d     = {carry_c, sum_c, q_q[width-1:1]};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            p_o     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            p_o     <= p_d;
        end
    end

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Scoreboard bench for mult_shift_add_ctrl: stimulus queues expected products
// and done cycles, a negedge monitor checks them as done_o appears.
module tb_mult_shift_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [2*W-1:0] p;
        int             done_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] p_o;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    mult_shift_add_ctrl #(.width(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .p_o     (p_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshake sanity every cycle, product and latency on each done.
    always @(negedge clk) begin
        if (!rst_i) begin
            tests++;
            if (busy_o && done_o) begin
                fails++;
                $display("FAIL busy_done_overlap cyc=%0d busy=%0b done=%0b required not both high", cyc, busy_o, done_o);
            end
            if (prev_done) begin
                tests++;
                if (done_o) begin
                    fails++;
                    $display("FAIL done_pulse_width cyc=%0d done=%0b required 0", cyc, done_o);
                end
            end
            if (done_o && !prev_done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done cyc=%0d p=%h", cyc, p_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (p_o !== e.p) begin
                        fails++;
                        $display("FAIL product cyc=%0d got=%h required=%h", cyc, p_o, e.p);
                    end
                    tests++;
                    if (cyc != e.done_cyc) begin
                        fails++;
                        $display("FAIL latency got_cyc=%0d required_cyc=%0d", cyc, e.done_cyc);
                    end
                end
            end
        end
        prev_done = done_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    // Block until the DUT is idle and every queued result has been seen.
    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o || done_o) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL wait_idle timeout cyc=%0d pending=%0d", cyc, exp_q.size());
        end
    endtask

    // Pulse start for one edge; operands are scrambled afterwards.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p, input bit push);
        exp_t e;
        wait_idle();
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        e.p        = p;
        e.done_cyc = cyc + 1 + int'(W);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        a_i     = W'($urandom);
        b_i     = W'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_done", 32'(done_o), 32'h0);
        check("reset_p", 32'(p_o), 32'h0);
        rst_i = 1'b0;
        @(negedge clk);

        // 0x0D * 0x0B: busy for exactly 8 cycles then done.
        issue(8'h0D, 8'h0B, 16'h008F, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("busy_run", 32'(busy_o), 32'h1);
            @(negedge clk);
        end
        check("busy_after_run", 32'(busy_o), 32'h0);
        check("done_after_run", 32'(done_o), 32'h1);

        issue(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        wait_idle();
        issue(8'h00, 8'hA5, 16'h0000, 1'b1);
        check("p_hold_at_accept", 32'(p_o), 32'h0000FE01);
        issue(8'hA5, 8'h00, 16'h0000, 1'b1);
        issue(8'h01, 8'h80, 16'h0080, 1'b1);
        issue(8'h80, 8'hFF, 16'h7F80, 1'b1);

        // Start held high: accepts every 10 cycles, operands garbled mid-run.
        wait_idle();
        begin
            int base;
            base = cyc + 1;
            start_i = 1'b1;
            for (int k = 0; k < 30; k++) begin
                if (k % 10 == 0) begin
                    exp_t e;
                    a_i = 8'd3;
                    b_i = 8'd5;
                    e.p        = 16'h000F;
                    e.done_cyc = base + k + int'(W);
                    exp_q.push_back(e);
                end else begin
                    a_i = 8'hFF;
                    b_i = 8'hEE;
                end
                @(negedge clk);
            end
            start_i = 1'b0;
        end

        // Reset mid-RUN aborts with no done and clears the product.
        issue(8'h12, 8'h34, 16'h03A8, 1'b0);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_done", 32'(done_o), 32'h0);
        check("abort_p", 32'(p_o), 32'h0);
        repeat (12) @(negedge clk);
        check("abort_p_later", 32'(p_o), 32'h0);
        issue(8'd2, 8'd3, 16'h0006, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0]   ra;
            logic [W-1:0]   rb;
            logic [2*W-1:0] rp;
            ra = W'($urandom);
            rb = W'($urandom);
            rp = (2*W)'(ra) * (2*W)'(rb);
            issue(ra, rb, rp, 1'b1);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
